// File: rtl/if_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Imported by if_fetch; holds bus widths, reset/pause encodings and word assembly.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int ByteBus     = 8;

  localparam logic [InstBus-1:0] ZeroWord     = '0;
  localparam logic               RstEnable    = 1'b0;
  localparam logic               PauseDisable = 1'b0;

  localparam logic [2:0] BytesPerInst = 3'd4;

  typedef logic [ByteBus-1:0] byte_t;

  // Little-endian assembly: lane 0 lands in bits 7:0, the final byte in 31:24.
  function automatic logic [InstBus-1:0] assemble(input byte_t top,
                                                  input logic [2:0][ByteBus-1:0] low);
    return {top, low[2], low[1], low[0]};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: reads a 32-bit instruction as four byte reads through an
// arbitrated 8-bit port, assembles it little-endian and presents it to IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int               ADDR_W   = InstAddrBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               stall_if,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_grant,
  input  logic [ByteBus-1:0] mem_rdata,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [InstBus-1:0] if_inst,
  output logic               if_valid
);

  logic [ADDR_W-1:0]        pc;
  logic [2:0]               issue_cnt;
  logic [1:0]               recv_cnt;
  logic                     inflight;
  logic [2:0][ByteBus-1:0]  lanes;
  logic                     hold;
  logic                     granted;

  // NOTE: every signal driven in always_comb gets a value on every path; defaults
  // first so no path can leave one unassigned and infer a latch.
  always_comb begin
    hold     = if_valid & (stall_if != PauseDisable);
    mem_req  = (rst != RstEnable) & rdy & (issue_cnt < BytesPerInst) & ~hold & ~branch_en;
    mem_addr = '0;
    if (mem_req) mem_addr = pc + ADDR_W'(issue_cnt);
    granted  = mem_req & mem_grant;
  end

  // NOTE: state registers use non-blocking assignments so every update in this block
  // sees the pre-edge values, matching how the flops actually behave.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc        <= RESET_PC;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inflight  <= 1'b0;
      if_pc     <= '0;
      if_inst   <= ZeroWord;
      if_valid  <= 1'b0;
    end else if (rdy && branch_en) begin
      // Redirect wins over stall and completion; a byte still in flight is dropped.
      pc        <= branch_target;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inflight  <= 1'b0;
      if_valid  <= 1'b0;
    end else begin
      inflight <= granted;
      if (granted) issue_cnt <= issue_cnt + 3'd1;

      if (inflight && recv_cnt == 2'd3) begin
        if_valid  <= 1'b1;
        if_pc     <= pc;
        if_inst   <= assemble(mem_rdata, lanes);
        pc        <= pc + ADDR_W'(4);
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (inflight) recv_cnt <= recv_cnt + 2'd1;
        // Handoff: an unstalled presented instruction is consumed at this edge.
        if (rdy && if_valid && stall_if == PauseDisable) if_valid <= 1'b0;
      end
    end
  end

  // NOTE: the byte lanes are pure datapath and are left out of reset; recv_cnt
  // restarting at zero guarantees every lane is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (rst != RstEnable && !(rdy && branch_en) && inflight) begin
      case (recv_cnt)
        2'd0:    lanes[0] <= mem_rdata;
        2'd1:    lanes[1] <= mem_rdata;
        2'd2:    lanes[2] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a byte memory model answers granted requests and a
// scoreboard queue holds the PC/instruction expected for each fetch started.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_if;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant;
  logic [7:0]  mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n;

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_if(stall_if),
    .branch_en(branch_en), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant),
    .mem_rdata(mem_rdata), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    case (a)
      32'h0:                return 8'h13;
      32'h1, 32'h2, 32'h3:  return 8'h00;
      default:              return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] p);
    return {mem_at(p + 32'd3), mem_at(p + 32'd2), mem_at(p + 32'd1), mem_at(p)};
  endfunction

  // Memory: the byte for a granted request appears the following cycle; junk otherwise.
  always @(posedge clk) begin
    if (mem_req && mem_grant) mem_rdata <= mem_at(mem_addr);
    else                      mem_rdata <= 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.inst = exp_word(p);
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=unexpected_instruction expected=empty_scoreboard", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_pc"}, if_pc, e.pc);
      check({tag, "_inst"}, if_inst, e.inst);
    end
  endtask

  // Advances until if_valid is seen or the budget runs out; n keeps counting from start.
  task automatic wait_valid(input string tag, input int start, output int cnt);
    cnt = start;
    while (!if_valid && cnt < start + 40) begin
      cyc();
      #1;
      cnt++;
    end
    check({tag, "_timeout"}, {31'b0, if_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; stall_if = 1'b0; branch_en = 1'b0;
    branch_target = 32'h0; mem_grant = 1'b1;

    // Reset state
    cyc(); cyc(); #1;
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'd0);

    // Basic fetch at RESET_PC with continuous grant
    rst = 1'b1; #1;
    push(32'h0);
    for (int i = 0; i < 4; i++) begin
      check("seq_req", {31'b0, mem_req}, 32'd1);
      check("seq_addr", mem_addr, 32'(i));
      cyc(); #1;
    end
    check("seq_idle_req", {31'b0, mem_req}, 32'd0);
    check("seq_early_valid", {31'b0, if_valid}, 32'd0);
    cyc(); #1;
    check("seq_valid_lat5", {31'b0, if_valid}, 32'd1);
    sb_check("seq");
    check("seq_next_addr", mem_addr, 32'h4);

    // Grant withheld on the 2nd request for 3 cycles
    push(32'h4);
    n = 0;
    cyc(); n++;
    mem_grant = 1'b0; #1;
    check("gnt_handoff_clear", {31'b0, if_valid}, 32'd0);
    check("gnt_addr_a", mem_addr, 32'h5);
    cyc(); n++; #1;
    check("gnt_addr_b", mem_addr, 32'h5);
    cyc(); n++; #1;
    check("gnt_addr_c", mem_addr, 32'h5);
    cyc(); n++;
    mem_grant = 1'b1; stall_if = 1'b1; #1;
    check("gnt_addr_d", mem_addr, 32'h5);
    wait_valid("gnt", n, n);
    check("gnt_latency", n, 32'd8);
    sb_check("gnt");

    // Stall held while presenting: outputs frozen, no prefetch
    for (int i = 0; i < 6; i++) begin
      check("stall_req", {31'b0, mem_req}, 32'd0);
      check("stall_pc", if_pc, 32'h4);
      check("stall_inst", if_inst, exp_word(32'h4));
      cyc(); #1;
    end
    stall_if = 1'b0; #1;
    check("stall_rel_req", {31'b0, mem_req}, 32'd1);
    check("stall_rel_addr", mem_addr, 32'h8);
    push(32'h8);
    cyc(); #1;
    check("stall_rel_clear", {31'b0, if_valid}, 32'd0);
    wait_valid("stall_next", 1, n);
    check("stall_next_lat", n, 32'd5);
    sb_check("stall_next");

    // Branch after two bytes received; in-flight byte discarded
    cyc(); cyc(); cyc();
    branch_en = 1'b1; branch_target = 32'h0000_1000; #1;
    check("br_req_blocked", {31'b0, mem_req}, 32'd0);
    cyc();
    branch_en = 1'b0; #1;
    check("br_valid_clear", {31'b0, if_valid}, 32'd0);
    check("br_addr", mem_addr, 32'h1000);
    push(32'h1000);
    wait_valid("br", 0, n);
    check("br_lat", n, 32'd5);
    sb_check("br");

    // Reset mid-fetch after two bytes
    cyc(); cyc(); cyc();
    rst = 1'b0; #1;
    check("mrst_req", {31'b0, mem_req}, 32'd0);
    cyc();
    rst = 1'b1; #1;
    check("mrst_valid", {31'b0, if_valid}, 32'd0);
    check("mrst_pc", if_pc, 32'h0);
    check("mrst_inst", if_inst, 32'h0);
    check("mrst_addr", mem_addr, 32'h0);
    push(32'h0);
    wait_valid("mrst", 0, n);
    check("mrst_lat", n, 32'd5);
    sb_check("mrst");

    // rdy low for 4 cycles after the first granted request; branch ignored meanwhile
    push(32'h4);
    for (int i = 0; i < 4; i++) begin
      cyc();
      rdy = 1'b0;
      branch_en = (i == 1);
      branch_target = 32'h0000_2000;
      #1;
      check("rdy_req", {31'b0, mem_req}, 32'd0);
    end
    cyc();
    rdy = 1'b1; branch_en = 1'b0; #1;
    check("rdy_resume_addr", mem_addr, 32'h5);
    wait_valid("rdy", 0, n);
    check("rdy_lat", n, 32'd4);
    sb_check("rdy");

    // Branch on the presentation cycle to an address that wraps
    branch_en = 1'b1; branch_target = 32'hFFFF_FFFE; #1;
    check("wrap_br_req", {31'b0, mem_req}, 32'd0);
    cyc();
    branch_en = 1'b0; #1;
    check("wrap_clear", {31'b0, if_valid}, 32'd0);
    push(32'hFFFF_FFFE);
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFE);
    cyc(); #1;
    check("wrap_addr1", mem_addr, 32'hFFFF_FFFF);
    cyc(); #1;
    check("wrap_addr2", mem_addr, 32'h0);
    cyc(); #1;
    check("wrap_addr3", mem_addr, 32'h1);
    wait_valid("wrap", 3, n);
    check("wrap_lat", n, 32'd5);
    sb_check("wrap");

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
